// File: rtl/memio_rdata_unit_pkg.sv
// Shared types and defaults for the load read-return unit: FSM states,
// access-size encodings and default bus widths.
package memio_rdata_unit_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_IO_CH  = 4;
    localparam int DEFAULT_IO_W   = 16;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        IO_WAIT,
        RESP
    } state_e;

    // A single channel still needs a one-bit select.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memio_rdata_unit_if.sv
// Request, memory, IO and writeback signals of the read-return unit.
// master = controller/memory/IO side, slave = the unit itself.
interface memio_rdata_unit_if #(
    parameter int DATA_W = memio_rdata_unit_pkg::DEFAULT_DATA_W,
    parameter int IO_CH  = memio_rdata_unit_pkg::DEFAULT_IO_CH,
    parameter int IO_W   = memio_rdata_unit_pkg::DEFAULT_IO_W,
    parameter int SEL_W  = memio_rdata_unit_pkg::sel_width(IO_CH)
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_mread;
    logic                  req_ioread;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [1:0]            req_addr_lo;
    logic [SEL_W-1:0]      req_io_sel;
    logic [DATA_W-1:0]     m_rdata;
    logic [IO_CH*IO_W-1:0] io_rdata;
    logic [IO_CH-1:0]      io_rvalid;
    logic [IO_CH-1:0]      io_rd_en;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     r_wdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_mread, req_ioread, req_size, req_unsigned,
               req_addr_lo, req_io_sel, m_rdata, io_rdata, io_rvalid,
        input  req_ready, io_rd_en, rsp_valid, r_wdata, rsp_err
    );

    modport slave (
        input  req_valid, req_mread, req_ioread, req_size, req_unsigned,
               req_addr_lo, req_io_sel, m_rdata, io_rdata, io_rvalid,
        output req_ready, io_rd_en, rsp_valid, r_wdata, rsp_err
    );

endinterface

// File: rtl/memio_rdata_unit_load_extend.sv
// Combinational byte/halfword lane select with sign or zero extension;
// word accesses pass the memory word through unchanged.
module memio_rdata_unit_load_extend
    import memio_rdata_unit_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        half_v = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: data = {{(DATA_W-8){byte_v[7] & ~is_unsigned}}, byte_v};
            SZ_HALF: data = {{(DATA_W-16){half_v[15] & ~is_unsigned}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/memio_rdata_unit.sv
// Load read-return unit: waits on Data-Memory (fixed latency) or one IO
// channel (valid handshake with timeout) and emits a registered writeback word.
module memio_rdata_unit
    import memio_rdata_unit_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int IO_CH   = DEFAULT_IO_CH,
    parameter int IO_W    = DEFAULT_IO_W,
    parameter int MEM_LAT = 1,
    parameter int TIMEOUT = 255,
    parameter int SEL_W   = sel_width(IO_CH)
) (
    input logic               clock,
    input logic               rst_n,
    memio_rdata_unit_if.slave bus
);

    localparam int CNT_MAX = (MEM_LAT > TIMEOUT) ? MEM_LAT : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [IO_CH-1:0]  io_rd_en_q, io_rd_en_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] r_wdata_q, r_wdata_d;

    logic              sel_legal;
    logic [IO_CH-1:0]  sel_onehot;
    logic              mem_misaligned;
    logic              io_hit;
    logic [IO_W-1:0]   io_ch_data;
    logic [DATA_W-1:0] ext_data;

    memio_rdata_unit_load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .rdata       (bus.m_rdata),
        .size        (size_q),
        .addr_lo     (addr_lo_q),
        .is_unsigned (unsigned_q),
        .data        (ext_data)
    );

    // Request decode; the selected channel's enable doubles as the
    // channel mask while waiting, so no select register is kept.
    always_comb begin
        sel_legal  = int'(bus.req_io_sel) < IO_CH;
        sel_onehot = '0;
        for (int k = 0; k < IO_CH; k++) begin
            sel_onehot[k] = (int'(bus.req_io_sel) == k);
        end
        mem_misaligned = (bus.req_size == SZ_RSVD)
                      || (bus.req_size == SZ_HALF && bus.req_addr_lo[0])
                      || (bus.req_size == SZ_WORD && bus.req_addr_lo != 2'b00);

        io_hit     = |(bus.io_rvalid & io_rd_en_q);
        io_ch_data = '0;
        for (int k = 0; k < IO_CH; k++) begin
            if (io_rd_en_q[k]) io_ch_data = bus.io_rdata[k*IO_W +: IO_W];
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        addr_lo_d   = addr_lo_q;
        io_rd_en_d  = io_rd_en_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        r_wdata_d   = r_wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    size_d     = bus.req_size;
                    unsigned_d = bus.req_unsigned;
                    addr_lo_d  = bus.req_addr_lo;
                    if (bus.req_ioread && sel_legal) begin
                        state_d    = IO_WAIT;
                        cnt_d      = '0;
                        io_rd_en_d = sel_onehot;
                    end else if (!bus.req_ioread && bus.req_mread && !mem_misaligned) begin
                        state_d = MEM_WAIT;
                        cnt_d   = CNT_W'(MEM_LAT - 1);
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        r_wdata_d   = '0;
                    end
                end
            end
            MEM_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    r_wdata_d   = ext_data;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            IO_WAIT: begin
                if (io_hit) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    r_wdata_d   = DATA_W'(io_ch_data);
                    io_rd_en_d  = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    r_wdata_d   = '0;
                    io_rd_en_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            size_q      <= SZ_BYTE;
            unsigned_q  <= 1'b0;
            addr_lo_q   <= 2'b00;
            io_rd_en_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            r_wdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed above.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            addr_lo_q   <= addr_lo_d;
            io_rd_en_q  <= io_rd_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            r_wdata_q   <= r_wdata_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.io_rd_en  = io_rd_en_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.r_wdata   = r_wdata_q;

endmodule

// File: tb/tb_memio_rdata_unit.sv
// Randomized bench for memio_rdata_unit: directed cases followed by random
// loads, each compared cycle by cycle against a transaction-level model.
module tb_memio_rdata_unit;

    localparam int DATA_W  = 32;
    localparam int IO_CH   = 4;
    localparam int IO_W    = 16;
    localparam int MEM_LAT = 1;
    localparam int TIMEOUT = 4;
    localparam int SEL_W   = 3;

    logic clock;
    logic rst_n;

    memio_rdata_unit_if #(
        .DATA_W(DATA_W), .IO_CH(IO_CH), .IO_W(IO_W), .SEL_W(SEL_W)
    ) bus ();

    memio_rdata_unit #(
        .DATA_W(DATA_W), .IO_CH(IO_CH), .IO_W(IO_W),
        .MEM_LAT(MEM_LAT), .TIMEOUT(TIMEOUT), .SEL_W(SEL_W)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outcome of one request: latency in clock edges after accept,
    // error flag, writeback word, and which source path is taken.
    task automatic model(
        input  logic mread, input logic ioread, input logic [1:0] size,
        input  logic uns, input logic [1:0] addr, input int sel,
        input  logic [31:0] mword, input logic [15:0] ioword, input int rv_at,
        output int lat, output logic err, output logic [31:0] data,
        output logic io_path, output logic mem_path
    );
        logic [31:0] v;
        io_path = 1'b0; mem_path = 1'b0; err = 1'b1; data = '0; lat = 0;
        if (ioread) begin
            if (sel < IO_CH) begin
                io_path = 1'b1;
                if (rv_at >= 1 && rv_at <= TIMEOUT) begin
                    lat = rv_at; err = 1'b0; data = 32'(ioword);
                end else begin
                    lat = TIMEOUT;
                end
            end
        end else if (mread) begin
            if (size == 2'd0 || (size == 2'd1 && addr % 2 == 0) || (size == 2'd2 && addr == 0)) begin
                mem_path = 1'b1; lat = MEM_LAT; err = 1'b0;
                if (size == 2'd0) begin
                    v = (mword >> (int'(addr) * 8)) & 32'hFF;
                    data = (!uns && v >= 32'd128) ? v + 32'hFFFF_FF00 : v;
                end else if (size == 2'd1) begin
                    v = (mword >> (int'(addr) / 2 * 16)) & 32'hFFFF;
                    data = (!uns && v >= 32'd32768) ? v + 32'hFFFF_0000 : v;
                end else begin
                    data = mword;
                end
            end
        end
    endtask

    // Source stimulus for the clock edge j cycles after accept: the real
    // memory word / IO data only where the model says they are sampled.
    task automatic drive_sources(
        input int j, input logic io_path, input logic mem_path, input int sel,
        input logic [31:0] mword, input logic [15:0] ioword, input int rv_at
    );
        logic [IO_CH*IO_W-1:0] rd;
        logic [IO_CH-1:0]      rv;
        logic [IO_CH-1:0]      mask;
        rd = {$urandom, $urandom};
        rv = IO_CH'($urandom);
        if (io_path) begin
            mask = IO_CH'(1 << sel);
            rv = (rv & ~mask) | ((j == rv_at) ? mask : '0);
            if (j == rv_at) rd[sel*IO_W +: IO_W] = ioword;
        end
        bus.io_rvalid = rv;
        bus.io_rdata  = rd;
        bus.m_rdata   = (mem_path && j == MEM_LAT) ? mword : $urandom;
    endtask

    // Called at a falling edge with the unit idle; returns at the falling edge
    // after it is idle again.
    task automatic run_txn(
        input logic mread, input logic ioread, input logic [1:0] size,
        input logic uns, input logic [1:0] addr, input int sel,
        input logic [31:0] mword, input logic [15:0] ioword, input int rv_at
    );
        int          lat;
        logic        exp_err, io_path, mem_path;
        logic [31:0] exp_data;
        logic [3:0]  en_mask;
        model(mread, ioread, size, uns, addr, sel, mword, ioword, rv_at,
              lat, exp_err, exp_data, io_path, mem_path);
        en_mask = io_path ? 4'(1 << sel) : 4'b0;

        check("ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_mread    = mread;
        bus.req_ioread   = ioread;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr_lo  = addr;
        bus.req_io_sel   = SEL_W'(sel);
        drive_sources(0, 1'b0, 1'b0, sel, mword, ioword, rv_at);
        @(posedge clock);

        for (int k = 0; k <= lat + 1; k++) begin
            @(negedge clock);
            check("rsp_valid", 32'(bus.rsp_valid), 32'(k == lat));
            check("io_rd_en", 32'(bus.io_rd_en), (k < lat) ? 32'(en_mask) : 32'd0);
            if (k < lat) check("ready_busy", 32'(bus.req_ready), 32'd0);
            if (k == lat) begin
                check("r_wdata", bus.r_wdata, exp_data);
                check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
                check("ready_resp", 32'(bus.req_ready), 32'd0);
            end
            if (k == lat + 1) begin
                check("ready_back", 32'(bus.req_ready), 32'd1);
                check("r_wdata_hold", bus.r_wdata, exp_data);
                check("rsp_err_hold", 32'(bus.rsp_err), 32'(exp_err));
            end
            if (k == 0) begin
                // Request fields must have been latched at accept.
                bus.req_valid    = 1'b0;
                bus.req_mread    = 1'($urandom);
                bus.req_ioread   = 1'($urandom);
                bus.req_size     = 2'($urandom);
                bus.req_unsigned = 1'($urandom);
                bus.req_addr_lo  = 2'($urandom);
                bus.req_io_sel   = SEL_W'($urandom);
            end
            drive_sources(k + 1, io_path, mem_path, sel, mword, ioword, rv_at);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_mread    = 1'b0;
        bus.req_ioread   = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr_lo  = 2'd0;
        bus.req_io_sel   = '0;
        bus.m_rdata      = '0;
        bus.io_rdata     = '0;
        bus.io_rvalid    = '0;

        #2;
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_r_wdata", bus.r_wdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_io_rd_en", 32'(bus.io_rd_en), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        // mread ioread size uns addr sel mword ioword rv_at
        run_txn(1, 0, 2'd0, 0, 2'd0, 0, 32'h1234_5680, 16'h0,    0);
        run_txn(1, 0, 2'd1, 1, 2'd2, 0, 32'h8001_7FFF, 16'h0,    0);
        run_txn(1, 0, 2'd1, 0, 2'd1, 0, 32'h8001_7FFF, 16'h0,    0);
        run_txn(0, 1, 2'd2, 0, 2'd0, 2, 32'h0,         16'hBEEF, 3);
        run_txn(0, 1, 2'd0, 0, 2'd0, 1, 32'h0,         16'h1234, 0);
        run_txn(1, 1, 2'd2, 0, 2'd0, 3, 32'hDEAD_BEEF, 16'hA5A5, 2);
        run_txn(0, 1, 2'd0, 0, 2'd0, 5, 32'h0,         16'h0,    1);
        run_txn(0, 0, 2'd2, 0, 2'd0, 0, 32'h0,         16'h0,    0);
        run_txn(1, 0, 2'd3, 0, 2'd0, 0, 32'hFFFF_FFFF, 16'h0,    0);
        run_txn(1, 0, 2'd2, 0, 2'd0, 0, 32'hCAFE_F00D, 16'h0,    0);
        run_txn(1, 0, 2'd2, 0, 2'd2, 0, 32'hCAFE_F00D, 16'h0,    0);
        run_txn(0, 1, 2'd0, 0, 2'd0, 0, 32'h0,         16'hFFFF, TIMEOUT);

        for (int n = 0; n < 300; n++) begin
            run_txn(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) == 0),
                    2'($urandom), 1'($urandom), 2'($urandom),
                    ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3)),
                    $urandom, 16'($urandom), int'($urandom_range(0, TIMEOUT + 2)));
        end

        // Reset while an IO read is outstanding.
        bus.req_valid  = 1'b1;
        bus.req_mread  = 1'b0;
        bus.req_ioread = 1'b1;
        bus.req_io_sel = SEL_W'(2);
        bus.io_rvalid  = '0;
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("abort_io_rd_en", 32'(bus.io_rd_en), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_io_rd_en_clr", 32'(bus.io_rd_en), 32'd0);
        check("abort_ready", 32'(bus.req_ready), 32'd1);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clock);
        check("abort_no_rsp_after", 32'(bus.rsp_valid), 32'd0);
        run_txn(1, 0, 2'd0, 1, 2'd3, 0, 32'h9ABC_DEF0, 16'h0, 0);
        run_txn(0, 1, 2'd0, 0, 2'd0, 2, 32'h0, 16'h5A5A, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/memio_rdata_unit.md
Name: memio_rdata_unit

Overview:
- Parametrised, sequential read-return unit between the Controller, Data-Memory, IO devices and the register-file writeback path.
- Accepts one load request at a time and waits for the source:
  - Data-Memory: fixed latency.
  - One of several IO channels: valid handshake with timeout.
- Extracts and extends byte/halfword/word (memory path only) and presents a registered writeback word with a one-cycle response pulse.

Parameters:
- DATA_W, 32, register/memory data width.
- IO_CH, 4, number of IO read channels.
- IO_W, 16, width of each IO channel's read data (IO_W <= DATA_W).
- MEM_LAT, 1, Data-Memory read latency in cycles (>= 1).
- TIMEOUT, 255, max cycles to wait for io_rvalid before error (>= 1).
- SEL_W, $clog2(IO_CH) (min 1), derived; IO channel select width.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request from Controller.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_mread  in  1  request targets Data-Memory.
- req_ioread  in  1  request targets IO; wins over req_mread when both are set.
- req_size  in  2  0=byte, 1=halfword, 2=word, 3=reserved (error).
- req_unsigned  in  1  zero-extend instead of sign-extend (byte/halfword).
- req_addr_lo  in  2  address bits [1:0] for lane select.
- req_io_sel  in  SEL_W  IO channel index.
- m_rdata  in  DATA_W  Data-Memory read data.
- io_rdata  in  IO_CH*IO_W  packed IO read data; channel k at [k*IO_W +: IO_W].
- io_rvalid  in  IO_CH  per-channel read data valid.
- io_rd_en  out  IO_CH  one-hot read strobe to the selected channel.
- rsp_valid  out  1  one-cycle pulse: r_wdata/rsp_err valid.
- r_wdata  out  DATA_W  data to register file.
- rsp_err  out  1  request failed; r_wdata = 0.

Behaviour:
- Reset (rst_n low, async): state IDLE, rsp_valid=0, r_wdata=0, rsp_err=0, io_rd_en=0, counters=0. req_ready is combinational from state, so it is 1 during reset.
- All outputs are registered except req_ready.
- States: IDLE, MEM_WAIT, IO_WAIT, RESP.
- Accept: req_valid & req_ready at rising edge E0. Request fields are latched at E0.
- IDLE -> IO_WAIT when req_ioread and req_io_sel < IO_CH.
- IDLE -> RESP with error when:
  - req_ioread and req_io_sel >= IO_CH;
  - neither read flag is set;
  - memory request with req_size=3;
  - memory request with halfword and addr_lo[0]=1;
  - memory request with word and addr_lo != 0.
- IDLE -> MEM_WAIT otherwise (req_mread only, legal alignment).
- MEM_WAIT:
  - Counter loads MEM_LAT-1 at E0 and decrements each edge.
  - m_rdata is sampled at edge E0+MEM_LAT.
  - Then -> RESP. rsp_valid is high for the cycle after edge E0+MEM_LAT.
- Memory extraction:
  - byte = lane addr_lo, i.e. bits [8*addr_lo +: 8];
  - halfword = bits [16*addr_lo[1] +: 16];
  - word = full DATA_W.
  - Sign- or zero-extension to DATA_W per req_unsigned.
- IO_WAIT:
  - io_rd_en[sel] is registered high from E0 through the edge on which io_rvalid[sel] is sampled high.
  - io_rd_en drops at that same edge; io_rdata[sel] is captured there, zero-extended to DATA_W.
  - req_size and req_unsigned are ignored for IO.
  - rsp_valid is high the next cycle.
- Timeout: the wait counter reaches TIMEOUT cycles without io_rvalid[sel] -> io_rd_en cleared, RESP with rsp_err=1, r_wdata=0.
- io_rvalid on non-selected channels is ignored.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE. r_wdata and rsp_err hold their values until the next response. A new request is accepted no earlier than the cycle after RESP (back-to-back throughput: one request per MEM_LAT+2 cycles on the memory path).
- Reset mid-operation: immediate return to IDLE; io_rd_en cleared asynchronously; no response is emitted for the aborted request.

Decomposition:
- Shared package holds:
  - state enum;
  - size encodings (SZ_BYTE/SZ_HALF/SZ_WORD);
  - default widths DATA_W/IO_W/IO_CH.
- One natural sub-module: load_extend, a combinational lane-select plus sign/zero-extension unit, parametrised on DATA_W.

Test Plan:
- Memory lb, MEM_LAT=1: m_rdata=0x12345680, addr_lo=0, signed byte -> rsp_valid 2 cycles after accept, r_wdata=0xFFFFFF80, rsp_err=0.
- Memory lhu, addr_lo=2: m_rdata=0x8001_7FFF -> r_wdata=0x00008001. Then lh with addr_lo=1 -> rsp_err=1, r_wdata=0, response 1 cycle after accept.
- IO read channel 2, io_rvalid[2] asserted 3 cycles after accept with io_rdata ch2=0xBEEF:
  - io_rd_en=4'b0100 for exactly 3 cycles;
  - r_wdata=0x0000BEEF;
  - io_rvalid[0] pulses during the wait are ignored.
- IO timeout, TIMEOUT=4, no io_rvalid -> rsp_err=1, r_wdata=0, io_rd_en deasserted, req_ready back high after RESP.
- Both req_mread and req_ioread set -> IO path taken (io_rd_en asserted, m_rdata ignored). Illegal io_sel=5 with IO_CH=4 -> immediate error.
- rst_n pulled low during IO_WAIT -> io_rd_en=0 and state IDLE asynchronously, no rsp_valid. The next request completes normally.
